// File: rtl/mips_bus_arbiter.sv
// rtl/mips_bus_arbiter.sv - two-master round-robin arbiter with per-transfer lock and slave watchdog
module mips_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TCW            = 11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m0_address,
    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [31:0] m0_writedata,
    input  logic [3:0]  m0_byteenable,
    output logic        m0_waitrequest,
    output logic [31:0] m0_readdata,
    input  logic [31:0] m1_address,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [31:0] m1_writedata,
    input  logic [3:0]  m1_byteenable,
    output logic        m1_waitrequest,
    output logic [31:0] m1_readdata,
    output logic [31:0] s_address,
    output logic        s_read,
    output logic        s_write,
    output logic [31:0] s_writedata,
    output logic [3:0]  s_byteenable,
    input  logic        s_waitrequest,
    input  logic [31:0] s_readdata,
    output logic [1:0]  grant,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    localparam logic [TCW-1:0] TLIM = TCW'(TIMEOUT_CYCLES);

    state_t         state;
    logic           last_owner;
    logic [TCW-1:0] tcnt;
    logic           req0;
    logic           req1;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // Arbitration, transfer locking and watchdog; grant is registered alongside the state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= 2'b00;
            last_owner  <= 1'b1;
            tcnt        <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tcnt <= '0;
                    // On a tie the master that did not finish last wins
                    if (req0 && (!req1 || last_owner)) begin
                        state <= GRANT0;
                        grant <= 2'b01;
                    end else if (req1) begin
                        state <= GRANT1;
                        grant <= 2'b10;
                    end
                end
                GRANT0: begin
                    if (!req0) begin
                        state <= IDLE;
                        grant <= 2'b00;
                        tcnt  <= '0;
                    end else if (!s_waitrequest) begin
                        last_owner <= 1'b0;
                        tcnt       <= '0;
                        // The finisher's own request is ignored so it cannot monopolise the bus
                        if (req1) begin
                            state <= GRANT1;
                            grant <= 2'b10;
                        end else begin
                            state <= IDLE;
                            grant <= 2'b00;
                        end
                    end else begin
                        if (tcnt != TLIM) tcnt <= tcnt + 1'b1;
                        if (tcnt >= TLIM - 1'b1) timeout_err <= 1'b1;
                    end
                end
                GRANT1: begin
                    if (!req1) begin
                        state <= IDLE;
                        grant <= 2'b00;
                        tcnt  <= '0;
                    end else if (!s_waitrequest) begin
                        last_owner <= 1'b1;
                        tcnt       <= '0;
                        if (req0) begin
                            state <= GRANT0;
                            grant <= 2'b01;
                        end else begin
                            state <= IDLE;
                            grant <= 2'b00;
                        end
                    end else begin
                        if (tcnt != TLIM) tcnt <= tcnt + 1'b1;
                        if (tcnt >= TLIM - 1'b1) timeout_err <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= 2'b00;
                end
            endcase
        end
    end

    // Slave-side mux driven only by the registered owner, so waitrequest never feeds back into requests
    always_comb begin
        s_address      = '0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        s_writedata    = '0;
        s_byteenable   = '0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        case (state)
            GRANT0: begin
                s_address      = m0_address;
                s_read         = m0_read & ~m0_write;
                s_write        = m0_write;
                s_writedata    = m0_writedata;
                s_byteenable   = m0_byteenable;
                m0_waitrequest = s_waitrequest;
            end
            GRANT1: begin
                s_address      = m1_address;
                s_read         = m1_read & ~m1_write;
                s_write        = m1_write;
                s_writedata    = m1_writedata;
                s_byteenable   = m1_byteenable;
                m1_waitrequest = s_waitrequest;
            end
            default: begin
                s_address = '0;
            end
        endcase
    end

    assign m0_readdata = s_readdata;
    assign m1_readdata = s_readdata;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// tb/tb_mips_bus_arbiter.sv - self-checking bench for mips_bus_arbiter
module tb_mips_bus_arbiter;

    localparam int TO = 8;
    localparam logic [7:0] TO8 = 8'd8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] m0_address = '0, m1_address = '0;
    logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
    logic [31:0] m0_writedata = '0, m1_writedata = '0;
    logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic [31:0] s_address, s_writedata;
    logic        s_read, s_write;
    logic [3:0]  s_byteenable;
    logic        s_waitrequest = 1'b0;
    logic [31:0] s_readdata = '0;
    logic [1:0]  grant;
    logic        timeout_err;

    int checks = 0;
    int failures = 0;
    bit started = 1'b0;
    int stall = 0;

    mips_bus_arbiter #(.TIMEOUT_CYCLES(TO), .TCW(4)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .grant(grant), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: owner is 0 (nobody), 1 (master 0) or 2 (master 1)
    typedef struct packed {
        logic [1:0] owner;
        logic       last;
        logic [7:0] cnt;
        logic       err;
    } mstate_t;

    localparam mstate_t MRESET = '{owner: 2'd0, last: 1'b1, cnt: 8'd0, err: 1'b0};

    mstate_t mst = MRESET;

    function automatic mstate_t model_next(input mstate_t m, input logic r0, input logic r1, input logic swr);
        mstate_t n;
        logic rn, ro;
        n = m;
        if (m.owner == 2'd0) begin
            n.cnt = 8'd0;
            if (r0 && r1)  n.owner = m.last ? 2'd1 : 2'd2;
            else if (r0)   n.owner = 2'd1;
            else if (r1)   n.owner = 2'd2;
        end else begin
            rn = (m.owner == 2'd1) ? r0 : r1;
            ro = (m.owner == 2'd1) ? r1 : r0;
            if (!rn) begin
                n.owner = 2'd0;
                n.cnt   = 8'd0;
            end else if (!swr) begin
                n.last  = (m.owner == 2'd2);
                n.owner = ro ? ((m.owner == 2'd1) ? 2'd2 : 2'd1) : 2'd0;
                n.cnt   = 8'd0;
            end else begin
                if (m.cnt < TO8) n.cnt = m.cnt + 8'd1;
                if (n.cnt >= TO8) n.err = 1'b1;
            end
        end
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) mst <= MRESET;
        else       mst <= model_next(mst, m0_read | m0_write, m1_read | m1_write, s_waitrequest);
    end

    function automatic logic [69:0] exp_bus(input logic [1:0] own);
        if (own == 2'd1) return {m0_address, m0_read & ~m0_write, m0_write, m0_writedata, m0_byteenable};
        if (own == 2'd2) return {m1_address, m1_read & ~m1_write, m1_write, m1_writedata, m1_byteenable};
        return 70'd0;
    endfunction

    function automatic logic [1:0] exp_wait(input logic [1:0] own);
        if (own == 2'd1) return {s_waitrequest, 1'b1};
        if (own == 2'd2) return {1'b1, s_waitrequest};
        return 2'b11;
    endfunction

    // Every cycle: outputs against the model
    always @(negedge clk) begin
        if (started) begin
            check("cmp_grant", 128'(grant), 128'({mst.owner == 2'd2, mst.owner == 2'd1}));
            check("cmp_slave_bus", 128'({s_address, s_read, s_write, s_writedata, s_byteenable}), 128'(exp_bus(mst.owner)));
            check("cmp_waitreq", 128'({m0_waitrequest, m1_waitrequest}), 128'(exp_wait(mst.owner)));
            check("cmp_readdata", 128'({m0_readdata, m1_readdata}), 128'({s_readdata, s_readdata}));
            check("cmp_timeout", 128'(timeout_err), 128'(mst.err));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
        m0_address = '0; m1_address = '0; m0_writedata = '0; m1_writedata = '0;
        m0_byteenable = '0; m1_byteenable = '0; s_waitrequest = 1'b0; s_readdata = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        step();
        step();
        reset = 1'b0;
        started = 1'b1;
    endtask

    initial begin
        // Reset state
        do_reset();
        reset = 1'b1;
        #1;
        check("rst_grant", 128'(grant), 128'(2'b00));
        check("rst_waits", 128'({m0_waitrequest, m1_waitrequest}), 128'(2'b11));
        check("rst_bus", 128'({s_address, s_read, s_write, s_writedata, s_byteenable}), 128'(0));
        check("rst_err", 128'(timeout_err), 128'(0));

        // Single master read with two wait cycles
        do_reset();
        m0_read = 1'b1; m0_address = 32'hBFC00000; s_waitrequest = 1'b1;
        step();
        @(negedge clk);
        check("t1_grant", 128'(grant), 128'(2'b01));
        check("t1_addr", 128'(s_address), 128'(32'hBFC00000));
        check("t1_m0wait", 128'(m0_waitrequest), 128'(1));
        step();
        step();
        s_waitrequest = 1'b0; s_readdata = 32'hDEAD0000;
        @(negedge clk);
        check("t1_m0wait_done", 128'(m0_waitrequest), 128'(0));
        check("t1_rdata", 128'(m0_readdata), 128'(32'hDEAD0000));
        check("t1_m1wait", 128'(m1_waitrequest), 128'(1));
        step();
        m0_read = 1'b0;
        @(negedge clk);
        check("t1_idle", 128'(grant), 128'(2'b00));

        // Simultaneous requests after reset
        do_reset();
        m0_read = 1'b1; m0_address = 32'h100;
        m1_write = 1'b1; m1_address = 32'h200; m1_writedata = 32'h12345678; m1_byteenable = 4'hF;
        step();
        @(negedge clk);
        check("t2_first", 128'(grant), 128'(2'b01));
        step();
        m0_read = 1'b0;
        @(negedge clk);
        check("t2_second", 128'(grant), 128'(2'b10));
        check("t2_write", 128'({s_write, s_read, s_address, s_writedata, s_byteenable}),
              128'({1'b1, 1'b0, 32'h200, 32'h12345678, 4'hF}));
        step();
        m1_write = 1'b0;
        @(negedge clk);
        check("t2_idle", 128'(grant), 128'(2'b00));

        // Round-robin with both masters requesting continuously
        do_reset();
        m0_read = 1'b1; m1_read = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            @(negedge clk);
            check($sformatf("t3_rr%0d", i), 128'(grant), 128'((i % 2 == 0) ? 2'b01 : 2'b10));
        end
        clear_inputs();

        // Lock under contention
        do_reset();
        m1_read = 1'b1; s_waitrequest = 1'b1;
        step();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("t4_lock%0d", c), 128'({grant, m0_waitrequest}), 128'({2'b10, 1'b1}));
            if (c == 1) m0_read = 1'b1;
            step();
        end
        s_waitrequest = 1'b0;
        @(negedge clk);
        check("t4_still_m1", 128'({grant, m0_waitrequest, m1_waitrequest}), 128'({2'b10, 1'b1, 1'b0}));
        step();
        m1_read = 1'b0;
        @(negedge clk);
        check("t4_handover", 128'(grant), 128'(2'b01));
        step();
        clear_inputs();

        // Watchdog
        do_reset();
        m0_read = 1'b1; s_waitrequest = 1'b1;
        step();
        for (int k = 1; k <= 10; k++) begin
            step();
            @(negedge clk);
            check($sformatf("t5_wd%0d", k), 128'(timeout_err), 128'(k >= TO));
        end
        s_waitrequest = 1'b0;
        step();
        m0_read = 1'b0;
        step();
        @(negedge clk);
        check("t5_sticky", 128'(timeout_err), 128'(1));
        do_reset();
        @(negedge clk);
        check("t5_cleared", 128'(timeout_err), 128'(0));

        // Asynchronous reset mid-transfer
        do_reset();
        m0_read = 1'b1; s_waitrequest = 1'b1;
        step();
        @(negedge clk);
        check("t6_pre", 128'({grant, s_read}), 128'({2'b01, 1'b1}));
        #2 reset = 1'b1;
        #1;
        check("t6_async", 128'({s_read, grant, m0_waitrequest, m1_waitrequest}), 128'({1'b0, 2'b00, 1'b1, 1'b1}));
        m1_read = 1'b1; s_waitrequest = 1'b0;
        step();
        reset = 1'b0;
        step();
        @(negedge clk);
        check("t6_after", 128'(grant), 128'(2'b01));
        clear_inputs();

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                m0_read = 1'($urandom_range(0, 1)); m0_write = 1'($urandom_range(0, 1));
                m0_address = $urandom; m0_writedata = $urandom; m0_byteenable = 4'($urandom);
            end
            if ($urandom_range(0, 7) == 0) begin
                m1_read = 1'($urandom_range(0, 1)); m1_write = 1'($urandom_range(0, 1));
                m1_address = $urandom; m1_writedata = $urandom; m1_byteenable = 4'($urandom);
            end
            if (stall == 0 && $urandom_range(0, 149) == 0) stall = 12;
            if (stall > 0) begin
                s_waitrequest = 1'b1;
                stall--;
            end else begin
                s_waitrequest = ($urandom_range(0, 9) < 5);
            end
            s_readdata = $urandom;
            if ($urandom_range(0, 499) == 0) begin
                #2 reset = 1'b1;
                #3 reset = 1'b0;
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_bus_arbiter.md
Name: mips_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the CPU memory bus, sharing a single RAM_32x4096-style slave between requesters.
- Requesters: master 0 is mips_cpu_bus; master 1 is a loader/DMA or test-harness master.
- Uses the same waitrequest-style read/write bus as the CPU, with round-robin grant and per-transfer locking.
- Includes a watchdog that flags a slave that never releases waitrequest.

Parameters:
- TIMEOUT_CYCLES, 1024: consecutive granted cycles with s_waitrequest=1 before timeout_err is set.
- TCW, 11: width of the timeout counter; must satisfy 2^TCW > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- m0_address  input  32  master 0 byte address
- m0_read  input  1  master 0 read request
- m0_write  input  1  master 0 write request
- m0_writedata  input  32  master 0 write data
- m0_byteenable  input  4  master 0 byte lanes
- m0_waitrequest  output  1  stall to master 0
- m0_readdata  output  32  read data to master 0
- m1_address / m1_read / m1_write / m1_writedata / m1_byteenable / m1_waitrequest / m1_readdata: same widths and meanings for master 1
- s_address  output  32  to slave
- s_read  output  1  to slave
- s_write  output  1  to slave
- s_writedata  output  32  to slave
- s_byteenable  output  4  to slave
- s_waitrequest  input  1  from slave
- s_readdata  input  32  from slave
- grant  output  2  one-hot current owner; 00 means idle
- timeout_err  output  1  sticky watchdog flag

Behaviour:
- Request definition: reqN = mN_read | mN_write. If both read and write are high, the transfer is a write and the read is suppressed toward the slave.
- States: IDLE, GRANT0, GRANT1. A registered last_owner bit provides round-robin priority.
- Reset (async): state=IDLE, last_owner=1 (master 0 wins the first tie), timeout counter=0, timeout_err=0.
  - Resulting outputs: grant=00, s_read=0, s_write=0, s_address=0, s_writedata=0, s_byteenable=0, m0_waitrequest=1, m1_waitrequest=1.
- IDLE:
  - Slave outputs are driven to 0; both waitrequests are 1.
  - If exactly one request is high, go to that GRANTn.
  - If both are high, go to the master that is not last_owner.
  - Grant takes effect on the next edge, so arbitration latency is 1 cycle.
- GRANTn:
  - s_* outputs are a combinational mux of master n's signals.
  - mn_waitrequest = s_waitrequest.
  - The other master's waitrequest = 1.
  - Both mN_readdata = s_readdata (broadcast); data is valid only for the owner in its completion cycle.
- Completion: reqN=1 and s_waitrequest=0 at the edge.
  - last_owner<=n.
  - If the other master is requesting, go directly to the other GRANT (no idle bubble).
  - Otherwise go to IDLE. The finishing master's still-asserted request is not considered, which prevents back-to-back monopolisation.
- Request drop: the owner deasserts reqN before completion (protocol violation). Go to IDLE; last_owner is unchanged; no error is flagged.
- Locking: the grant never changes while the owner has an incomplete transfer, even if the other master requests.
- Watchdog:
  - The counter increments each cycle in GRANTn with s_waitrequest=1.
  - It clears on completion, in IDLE, and on request drop.
  - When the counter reaches TIMEOUT_CYCLES, timeout_err<=1 (sticky until reset). The counter saturates.
  - Arbitration continues unaffected.
- Reset mid-transfer: immediate return to IDLE with the reset output values. The slave sees read/write drop asynchronously, and the in-flight transfer is abandoned.
- No combinational path from s_waitrequest to grant or to the s_* request outputs.

Test Plan:
- Single master read:
  - Stimulus: m0_read=1, m0_address=0xBFC00000; slave returns 0xDEAD0000 with 2 wait cycles.
  - Required: grant=01 one cycle after the request; m0_readdata=0xDEAD0000 while m0_waitrequest=0; state returns to IDLE next cycle; m1_waitrequest=1 throughout.
- Simultaneous requests after reset:
  - Stimulus: m0 read 0x100 and m1 write 0x200 (data 0x12345678, byteenable 0xF) raised together.
  - Required: m0 served first; grant goes 01 then 10 with no IDLE cycle between; the slave sees write 0x12345678 at 0x200 with byteenable 0xF.
- Round-robin fairness:
  - Stimulus: both masters hold requests continuously for 6 transfers.
  - Required: grant sequence 01,10,01,10,01,10; neither master is served twice consecutively.
- Lock under contention:
  - Stimulus: m1 owns the bus with s_waitrequest=1 for 5 cycles; m0 requests at cycle 2.
  - Required: grant stays 10 until m1 completes, then becomes 01; m0_waitrequest=1 throughout.
- Watchdog:
  - Stimulus: TIMEOUT_CYCLES=8, slave holds waitrequest=1.
  - Required: timeout_err rises exactly 8 cycles after the grant and stays high after the slave later releases; cleared only by reset.
- Async reset mid-transfer:
  - Stimulus: assert reset between edges during GRANT0.
  - Required: s_read=0, grant=00, and both waitrequests=1 immediately, without waiting for a clock edge.
  - After reset is released with both masters requesting, master 0 is granted first.
